// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// No logic; pure declarations plus one index helper.
// No backpressure.
package uart_arb_pkg;

    localparam int MSG_CNT_W = 4;
    localparam int BYTE_W    = 8;

    // IDLE: no owner; ISSUE: owner may hand over a byte; GUARD: busy-rise
    // window after a strobe; DRAIN: waiting for the serializer to go idle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    // (a + b) mod n for a < n and b <= n, avoiding a real divider.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams, serializer strobe/busy and status bundled together.
// No logic; wiring only.
// Backpressure is the per-requester ready plus the serializer busy flag.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 2
);
    import uart_arb_pkg::*;

    logic [N_REQ-1:0]              i_req_valid;
    logic [N_REQ-1:0]              i_req_last;
    logic [N_REQ-1:0][BYTE_W-1:0]  i_req_data;
    logic [N_REQ-1:0]              o_req_ready;
    logic [BYTE_W-1:0]             o_tx_data;
    logic                          o_tx_stb;
    logic                          i_tx_busy;
    logic [N_REQ-1:0]              o_grant;
    logic [MSG_CNT_W-1:0]          o_msg_count;

    // Environment side: requesters and the serializer.
    modport master (
        output i_req_valid, i_req_last, i_req_data, i_tx_busy,
        input  o_req_ready, o_tx_data, o_tx_stb, o_grant, o_msg_count
    );

    // Arbiter side.
    modport slave (
        input  i_req_valid, i_req_last, i_req_data, i_tx_busy,
        output o_req_ready, o_tx_data, o_tx_stb, o_grant, o_msg_count
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
// Latency 0 (purely combinational).
// No backpressure; gnt_vld low when no request is asserted.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_vld
);

    // Scan requesters starting at ptr; the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_vld && req[wrap_add(int'(ptr), i, N_REQ)]) begin
                gnt[wrap_add(int'(ptr), i, N_REQ)] = 1'b1;
                gnt_vld                            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among N_REQ byte streams, round-robin per message.
// Handshake -> o_tx_stb 1 cycle; byte period 2 + GUARD_CYCLES + serializer frame.
// Owner's ready only when serializer idle in ISSUE; others never ready; stalled owner released after LOCK_TIMEOUT.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int GUARD_CYCLES = 1,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    uart_tx_arbiter_if.slave  bus
);

    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // A zero-length guard would let DRAIN see a stale idle busy flag.
    localparam int GUARD_N = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
    localparam int GRD_W   = $clog2(GUARD_N + 1);
    localparam int TO_N    = (LOCK_TIMEOUT < 1) ? 1 : LOCK_TIMEOUT;
    localparam int TO_W    = $clog2(TO_N + 1);

    arb_state_t            state_q,     state_d;
    logic [N_REQ-1:0]      grant_q,     grant_d;
    logic [PTR_W-1:0]      owner_q,     owner_d;
    logic [PTR_W-1:0]      rr_ptr_q,    rr_ptr_d;
    logic                  last_q,      last_d;
    logic                  stb_q,       stb_d;
    logic [BYTE_W-1:0]     data_q,      data_d;
    logic [MSG_CNT_W-1:0]  msg_cnt_q,   msg_cnt_d;
    logic [GRD_W-1:0]      guard_cnt_q, guard_cnt_d;
    logic [TO_W-1:0]       to_cnt_q,    to_cnt_d;

    logic [N_REQ-1:0]      pick_gnt;
    logic                  pick_vld;
    logic [PTR_W-1:0]      pick_idx;
    logic [PTR_W-1:0]      next_ptr;
    logic                  owner_vld;
    logic                  owner_last;
    logic [BYTE_W-1:0]     owner_data;
    logic                  hs;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req     (bus.i_req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (pick_gnt),
        .gnt_vld (pick_vld)
    );

    assign owner_vld  = bus.i_req_valid[owner_q];
    assign owner_last = bus.i_req_last[owner_q];
    assign owner_data = bus.i_req_data[owner_q];
    assign hs         = (state_q == ST_ISSUE) && owner_vld && !bus.i_tx_busy;
    assign next_ptr   = PTR_W'(wrap_add(int'(owner_q), 1, N_REQ));

    // Encode the one-hot pick into an index for the owner register.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    // Only the owner may see ready, and only while the serializer is idle.
    always_comb begin
        bus.o_req_ready = '0;
        if (hs) begin
            bus.o_req_ready[owner_q] = 1'b1;
        end
    end

    // Next-state and register updates for the grant/issue/drain cycle.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        last_d      = last_q;
        stb_d       = 1'b0;
        data_d      = data_q;
        msg_cnt_d   = msg_cnt_q;
        guard_cnt_d = guard_cnt_q;
        to_cnt_d    = to_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d  = pick_gnt;
                    owner_d  = pick_idx;
                    to_cnt_d = '0;
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (hs) begin
                    stb_d       = 1'b1;
                    data_d      = owner_data;
                    last_d      = owner_last;
                    to_cnt_d    = '0;
                    guard_cnt_d = '0;
                    state_d     = ST_GUARD;
                end else if (!owner_vld) begin
                    // Stalled owner: after TO_N idle cycles give the UART
                    // away without counting the message as completed.
                    if (to_cnt_q == TO_W'(TO_N - 1)) begin
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        to_cnt_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end

            ST_GUARD: begin
                if (guard_cnt_q == GRD_W'(GUARD_N - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    guard_cnt_d = guard_cnt_q + GRD_W'(1);
                end
            end

            ST_DRAIN: begin
                if (!bus.i_tx_busy) begin
                    if (last_q) begin
                        msg_cnt_d = msg_cnt_q + MSG_CNT_W'(1);
                        rr_ptr_d  = next_ptr;
                        grant_d   = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d   = ST_ISSUE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            last_q      <= 1'b0;
            stb_q       <= 1'b0;
            data_q      <= '0;
            msg_cnt_q   <= '0;
            guard_cnt_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            last_q      <= last_d;
            stb_q       <= stb_d;
            data_q      <= data_d;
            msg_cnt_q   <= msg_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign bus.o_grant     = grant_q;
    assign bus.o_tx_stb    = stb_q;
    assign bus.o_tx_data   = data_q;
    assign bus.o_msg_count = msg_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with two requesters and a busy-flag serializer model.
// Serializer model: busy rises the cycle after a strobe and stays high for 10 cycles.
// Requesters present queued {last,data} entries and pop on valid & ready.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N         = 2;
    localparam int LT        = 8;
    localparam int BUSY_BITS = 10;

    logic clk;
    logic rst;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(
        .N_REQ        (N),
        .GUARD_CYCLES (1),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [15:0] log_q[$];
    int          viol = 0;
    logic [1:0]  hs;
    int          busy_cnt;
    logic        stb_seen;

    logic [15:0] exp2 [3] = '{16'h003A, 16'h0030, 16'h000A};
    logic [15:0] exp3 [8] = '{16'h00A0, 16'h00A1, 16'h01B0, 16'h01B1,
                              16'h00A2, 16'h00A3, 16'h01B2, 16'h01B3};
    logic [15:0] exp4 [4] = '{16'h00C0, 16'h00C1, 16'h00C2, 16'h01D0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Requester and serializer models: pop at posedge, drive just after it,
    // sample handshake/strobe at negedge.
    initial begin
        bus.i_req_valid = '0;
        bus.i_req_last  = '0;
        bus.i_req_data  = '0;
        bus.i_tx_busy   = 1'b0;
        hs              = '0;
        busy_cnt        = 0;
        stb_seen        = 1'b0;
        forever begin
            @(posedge clk);
            if (hs[0] && q0.size() > 0) void'(q0.pop_front());
            if (hs[1] && q1.size() > 0) void'(q1.pop_front());
            #1;
            if (stb_seen) busy_cnt = BUSY_BITS;
            else if (busy_cnt > 0) busy_cnt--;
            bus.i_tx_busy = (busy_cnt != 0);
            bus.i_req_valid[0] = (q0.size() > 0);
            if (q0.size() > 0) {bus.i_req_last[0], bus.i_req_data[0]} = q0[0];
            else bus.i_req_last[0] = 1'b0;
            bus.i_req_valid[1] = (q1.size() > 0);
            if (q1.size() > 0) {bus.i_req_last[1], bus.i_req_data[1]} = q1[0];
            else bus.i_req_last[1] = 1'b0;
            @(negedge clk);
            hs       = bus.i_req_valid & bus.o_req_ready;
            stb_seen = bus.o_tx_stb;
            if (bus.o_tx_stb) begin
                log_q.push_back({7'd0, bus.o_grant[1], bus.o_tx_data});
                if (bus.i_tx_busy) viol++;
            end
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        repeat (n) @(negedge clk);
        rst = 1'b1;
    endtask

    // Wait until both streams are drained, grant dropped and the UART idle.
    task automatic wait_done(input string tag, input int budget);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (q0.size() == 0) && (q1.size() == 0) &&
                   (bus.o_grant == '0) && !bus.i_tx_busy;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    // Wait until at least 'cnt' strobes have been logged.
    task automatic wait_log(input string tag, input int cnt, input int budget);
        int n;
        n = 0;
        while (log_q.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(log_q.size() >= cnt), 32'd1);
    endtask

    initial begin
        int base;
        int v0;
        int hold;
        int n;

        // 1: reset held 3 cycles with both requesters valid.
        rst = 1'b0;
        q0.push_back(9'h155);
        q1.push_back(9'h166);
        base = log_q.size();
        repeat (3) @(negedge clk);
        chk("t1_grant",  32'(bus.o_grant),     32'd0);
        chk("t1_ready",  32'(bus.o_req_ready), 32'd0);
        chk("t1_stb",    32'(bus.o_tx_stb),    32'd0);
        chk("t1_data",   32'(bus.o_tx_data),   32'd0);
        chk("t1_count",  32'(bus.o_msg_count), 32'd0);
        chk("t1_nostb",  32'(log_q.size() - base), 32'd0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 2: single 3-byte message from req0.
        do_reset(2);
        base = log_q.size();
        v0   = viol;
        q0.push_back(9'h03A);
        q0.push_back(9'h030);
        q0.push_back(9'h10A);
        wait_done("t2_done", 300);
        chk("t2_nbytes", 32'(log_q.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) chk($sformatf("t2_byte%0d", i), 32'(log_q[base + i]), 32'(exp2[i]));
        chk("t2_count", 32'(bus.o_msg_count), 32'd1);
        chk("t2_grant", 32'(bus.o_grant), 32'd0);
        chk("t2_busy_stb", 32'(viol - v0), 32'd0);

        // 3: both requesters valid from the start, two 2-byte messages each.
        do_reset(2);
        base = log_q.size();
        v0   = viol;
        q0.push_back(9'h0A0); q0.push_back(9'h1A1);
        q0.push_back(9'h0A2); q0.push_back(9'h1A3);
        q1.push_back(9'h0B0); q1.push_back(9'h1B1);
        q1.push_back(9'h0B2); q1.push_back(9'h1B3);
        wait_done("t3_done", 800);
        chk("t3_nbytes", 32'(log_q.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("t3_byte%0d", i), 32'(log_q[base + i]), 32'(exp3[i]));
        chk("t3_count", 32'(bus.o_msg_count), 32'd4);
        chk("t3_busy_stb", 32'(viol - v0), 32'd0);

        // 4: req1 arrives in the middle of req0's message.
        do_reset(2);
        base = log_q.size();
        q0.push_back(9'h0C0);
        q0.push_back(9'h0C1);
        q0.push_back(9'h1C2);
        wait_log("t4_first", base + 1, 100);
        q1.push_back(9'h1D0);
        wait_done("t4_done", 400);
        chk("t4_nbytes", 32'(log_q.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("t4_byte%0d", i), 32'(log_q[base + i]), 32'(exp4[i]));
        chk("t4_count", 32'(bus.o_msg_count), 32'd2);

        // 5: req0 stalls after its first byte; req1 waiting.
        // Grant to req0 with valid, busy and stb all low lasts one DRAIN cycle
        // plus LT idle ISSUE cycles before the forced release.
        do_reset(2);
        base = log_q.size();
        v0   = viol;
        hold = 0;
        n    = 0;
        q0.push_back(9'h0E0);
        q1.push_back(9'h1F0);
        while (bus.o_grant != 2'b10 && n < 300) begin
            @(negedge clk);
            n++;
            if (bus.o_grant == 2'b01 && !bus.i_req_valid[0] && !bus.i_tx_busy && !bus.o_tx_stb) hold++;
        end
        chk("t5_req1_grant", 32'(bus.o_grant), 32'd2);
        chk("t5_hold", 32'(hold), 32'(LT + 1));
        wait_done("t5_done", 300);
        chk("t5_byte0", 32'(log_q[base]),     32'h00E0);
        chk("t5_byte1", 32'(log_q[base + 1]), 32'h01F0);
        chk("t5_count", 32'(bus.o_msg_count), 32'd1);
        chk("t5_busy_stb", 32'(viol - v0), 32'd0);

        // 6: reset while draining the first byte, then a normal message.
        do_reset(2);
        base = log_q.size();
        v0   = viol;
        q0.push_back(9'h047);
        q0.push_back(9'h148);
        wait_log("t6_first", base + 1, 100);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q0.delete();
        @(negedge clk);
        chk("t6_grant", 32'(bus.o_grant),     32'd0);
        chk("t6_stb",   32'(bus.o_tx_stb),    32'd0);
        chk("t6_ready", 32'(bus.o_req_ready), 32'd0);
        chk("t6_count", 32'(bus.o_msg_count), 32'd0);
        rst = 1'b1;
        q1.push_back(9'h148);
        wait_done("t6_done", 300);
        chk("t6_nbytes", 32'(log_q.size() - base), 32'd2);
        chk("t6_byte1", 32'(log_q[base + 1]), 32'h0148);
        chk("t6_count_after", 32'(bus.o_msg_count), 32'd1);
        chk("t6_busy_stb", 32'(viol - v0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
